// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin arbiter/sequencer sharing one aes_core between NREQ requesters.
// Ports: clk/rst_n (async active-low); req_valid/req_ready plus per-requester req_key/req_data/req_size/req_dec
// job channel; rsp_valid/rsp_ready plus shared rsp_data/rsp_timeout response channel; core_load/core_key/
// core_data/core_size/core_dec drive the core; core_result/core_busy come back from it.
module aes_core_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [256*NREQ-1:0]  req_key,
  input  logic [128*NREQ-1:0]  req_data,
  input  logic [2*NREQ-1:0]    req_size,
  input  logic [NREQ-1:0]      req_dec,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [127:0]         rsp_data,
  output logic                 rsp_timeout,
  output logic                 core_load,
  output logic [255:0]         core_key,
  output logic [127:0]         core_data,
  output logic [1:0]           core_size,
  output logic                 core_dec,
  input  logic [127:0]         core_result,
  input  logic                 core_busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, RESP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_gnt, w_gnt, w_idx, w_ptr_nxt;
  logic w_found, w_done, w_tmo, w_acc;
  logic [7:0] r_cnt;
  logic [127:0] r_rsp_data, r_data;
  logic [255:0] r_key;
  logic [1:0] r_size;
  logic r_rsp_timeout, r_dec;
  // first valid requester at or after ptr, searching upward with wrap
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  // completion beats the watchdog when both happen in the same cycle
  assign w_done = (r_state == RUN) && !core_busy;
  assign w_tmo = (r_state == RUN) && core_busy && (r_cnt == 8'(TIMEOUT - 1));
  assign w_acc = (r_state == RESP) && rsp_ready[r_gnt];
  assign w_ptr_nxt = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + IW'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_found ? LOAD : IDLE;
      LOAD: w_next = ARM;
      ARM: w_next = RUN;
      RUN: w_next = (w_done || w_tmo) ? RESP : RUN;
      RESP: w_next = w_acc ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_gnt <= '0;
      r_cnt <= '0;
      r_rsp_data <= '0;
      r_rsp_timeout <= 1'b0;
      r_key <= '0;
      r_data <= '0;
      r_size <= '0;
      r_dec <= 1'b0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_gnt <= w_gnt;
        r_key <= req_key[256*w_gnt +: 256];
        r_data <= req_data[128*w_gnt +: 128];
        r_size <= req_size[2*w_gnt +: 2];
        r_dec <= req_dec[w_gnt];
      end
      r_cnt <= (r_state == ARM) ? 8'd0 : (r_state == RUN) ? r_cnt + 8'd1 : r_cnt;
      if (w_done) begin
        r_rsp_data <= core_result;
        r_rsp_timeout <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_data <= '0;
        r_rsp_timeout <= 1'b1;
      end
      if (w_acc) r_ptr <= w_ptr_nxt;
    end
  end
  // decoded from state so reset drops them without waiting for a clock
  assign req_ready = (r_state == IDLE && w_found) ? (NREQ'(1) << w_gnt) : '0;
  assign rsp_valid = (r_state == RESP) ? (NREQ'(1) << r_gnt) : '0;
  assign core_load = (r_state == LOAD);
  assign rsp_data = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  assign core_key = r_key;
  assign core_data = r_data;
  assign core_size = r_size;
  assign core_dec = r_dec;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: table-driven and scoreboard checks of aes_core_arbiter against a behavioural core model.
module tb_aes_core_arbiter;
  localparam int NREQ = 2;
  localparam int TO = 16;
  localparam logic [255:0] KEY = {128'd0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req_valid, req_ready, req_dec, rsp_valid, rsp_ready;
  logic [256*NREQ-1:0] req_key;
  logic [128*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_size;
  logic [127:0] rsp_data, core_data, core_result;
  logic rsp_timeout, core_load, core_dec, core_busy;
  logic [255:0] core_key;
  logic [1:0] core_size;
  logic [255:0] k_a [NREQ];
  logic [127:0] d_a [NREQ];
  logic [1:0] s_a [NREQ];
  logic dc_a [NREQ];
  int lat_a [NREQ];
  always #5 clk = ~clk;
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req_key[256*i +: 256] = k_a[i];
    assign req_data[128*i +: 128] = d_a[i];
    assign req_size[2*i +: 2] = s_a[i];
    assign req_dec[i] = dc_a[i];
  end
  aes_core_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_data(req_data), .req_size(req_size), .req_dec(req_dec), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .core_load(core_load),
    .core_key(core_key), .core_data(core_data), .core_size(core_size), .core_dec(core_dec),
    .core_result(core_result), .core_busy(core_busy)
  );
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] d, input logic [1:0] s,
                                           input logic dc);
    if (k == KEY && s == 2'd0 && !dc && d == PT) return CT;
    if (k == KEY && s == 2'd0 && dc && d == CT) return PT;
    return d ^ k[127:0] ^ k[255:128] ^ {dc, 125'd0, s};
  endfunction
  // core model: busy rises the edge after load and stays high for lat_cfg cycles
  int lat_cfg = 4;
  int c_rem = 0;
  logic c_busy = 1'b0;
  logic [127:0] c_res = '0;
  assign core_busy = c_busy;
  assign core_result = c_res;
  always @(posedge clk) begin
    if (core_load) begin
      c_busy <= 1'b1;
      c_rem <= lat_cfg;
      c_res <= core_fn(core_key, core_data, core_size, core_dec);
    end else if (c_busy) begin
      if (c_rem <= 1) c_busy <= 1'b0;
      else c_rem <= c_rem - 1;
    end
  end
  typedef struct {int id; logic [127:0] data; logic tmo;} exp_t;
  typedef struct {
    int id; logic [255:0] key; logic [127:0] data; logic [1:0] size; logic dec; int lat;
    logic [127:0] edata; logic etmo; int elat;
  } vec_t;
  exp_t sb[$];
  vec_t tv[8];
  int tests = 0, fails = 0;
  bit load_pend = 0;
  int g, w;
  logic [NREQ-1:0] rv;
  logic [127:0] rd;
  logic ok;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask
  always @(negedge clk) if (rst_n) begin
    if (core_load) begin
      chk("load_overlap", {255'd0, load_pend}, 256'd0);
      load_pend = 1;
    end
    if ((rsp_valid & rsp_ready) != 0) begin
      load_pend = 0;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: response %b with nothing expected", rsp_valid);
      end else begin
        exp_t e;
        logic [NREQ-1:0] ev;
        e = sb.pop_front();
        ev = NREQ'(1) << e.id;
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end
  task automatic set_req(input int id, input logic [255:0] k, input logic [127:0] d, input logic [1:0] s,
                         input logic dc, input int l);
    k_a[id] = k;
    d_a[id] = d;
    s_a[id] = s;
    dc_a[id] = dc;
    lat_a[id] = l;
  endtask
  task automatic wait_grant(output int gi, output int wi);
    gi = -1;
    wi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wi++;
      if (req_ready != 0) break;
    end
    if (req_ready == 0) begin
      tests++;
      fails++;
      $display("FAIL grant_wait: req_ready stayed %b", req_ready);
      finish_tb();
    end
    chk("ready_onehot", {255'd0, $onehot(req_ready)}, 256'd1);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
    lat_cfg = lat_a[gi];
  endtask
  task automatic wait_rsp(input int gi, input int exp_n);
    int n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("load_pulse", core_load, 1);
        chk("core_key", core_key, k_a[gi]);
        chk("core_data", core_data, d_a[gi]);
        chk("core_size", core_size, s_a[gi]);
        chk("core_dec", core_dec, dc_a[gi]);
      end
      if (rsp_valid != 0) break;
    end
    chk("rsp_latency", n, exp_n);
    if (rsp_valid == 0) finish_tb();
  endtask
  task automatic handshake();
    @(posedge clk);
    #1 rsp_ready = '1;
    @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = '0;
  endtask
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_tb();
  end
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, 2'd0, 1'b0, 4);
    tv[0] = '{0, KEY, PT, 2'd0, 1'b0, 10, CT, 1'b0, 13};
    tv[1] = '{1, KEY, CT, 2'd0, 1'b1, 12, PT, 1'b0, 15};
    tv[2] = '{0, {8{32'hdeadbeef}}, 128'h1, 2'd1, 1'b0, 1, '0, 1'b0, 4};
    tv[3] = '{1, {8{32'h12345678}}, {4{32'hcafef00d}}, 2'd2, 1'b1, 7, '0, 1'b0, 10};
    tv[4] = '{0, {8{32'h0badc0de}}, {4{32'h5a5a5a5a}}, 2'd3, 1'b0, TO, '0, 1'b0, TO + 3};
    tv[5] = '{1, {8{32'h11112222}}, {4{32'h33334444}}, 2'd0, 1'b0, TO + 1, '0, 1'b1, TO + 3};
    tv[6] = '{0, {8{32'h55556666}}, {4{32'h77778888}}, 2'd2, 1'b0, 1000, '0, 1'b1, TO + 3};
    tv[7] = '{1, {8{32'h9999aaaa}}, {4{32'hbbbbcccc}}, 2'd1, 1'b1, 6, '0, 1'b0, 9};
    foreach (tv[i]) if (!tv[i].etmo && tv[i].key != KEY) tv[i].edata = core_fn(tv[i].key, tv[i].data, tv[i].size, tv[i].dec);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_core_size_dec", {core_size, core_dec}, 0);
    // contention: both requesters held valid for four jobs
    set_req(0, {8{32'ha0a0a0a0}}, {4{32'h01020304}}, 2'd0, 1'b0, 3);
    set_req(1, {8{32'hb1b1b1b1}}, {4{32'h05060708}}, 2'd2, 1'b1, 5);
    @(posedge clk);
    #1 req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_grant(g, w);
      chk("cont_grant", g, j % 2);
      sb.push_back('{g, core_fn(k_a[g], d_a[g], s_a[g], dc_a[g]), 1'b0});
      wait_rsp(g, lat_a[g] + 3);
      handshake();
    end
    req_valid = '0;
    // single-requester vectors
    foreach (tv[i]) begin
      set_req(tv[i].id, tv[i].key, tv[i].data, tv[i].size, tv[i].dec, tv[i].lat);
      @(posedge clk);
      #1 req_valid[tv[i].id] = 1'b1;
      wait_grant(g, w);
      chk("vec_grant", g, tv[i].id);
      sb.push_back('{tv[i].id, tv[i].edata, tv[i].etmo});
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(g, tv[i].elat);
      handshake();
    end
    // backpressure: response held 20 cycles while the other requester waits
    set_req(1, {8{32'h13579bdf}}, {4{32'h2468ace0}}, 2'd0, 1'b0, 4);
    set_req(0, {8{32'hfedcba98}}, {4{32'h76543210}}, 2'd1, 1'b0, 2);
    @(posedge clk);
    #1 req_valid = 2'b10;
    wait_grant(g, w);
    chk("bp_grant", g, 1);
    sb.push_back('{1, core_fn(k_a[1], d_a[1], s_a[1], dc_a[1]), 1'b0});
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(1, 7);
    rv = rsp_valid;
    rd = rsp_data;
    ok = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 2'b01;
    req_valid = 2'b01;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== rv || rsp_data !== rd || req_ready !== '0 || core_load !== 1'b0) ok = 1'b0;
    end
    chk("bp_hold_stable", ok, 1);
    @(posedge clk);
    #1 rsp_ready = 2'b10;
    @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = '0;
    wait_grant(g, w);
    chk("bp_next_grant", g, 0);
    chk("bp_next_delay", w, 1);
    sb.push_back('{0, core_fn(k_a[0], d_a[0], s_a[0], dc_a[0]), 1'b0});
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(0, 5);
    handshake();
    // reset during RUN with ptr at 1, then both requesters contend
    set_req(1, {8{32'h0f0f0f0f}}, {4{32'hf0f0f0f0}}, 2'd2, 1'b1, 50);
    set_req(0, {8{32'h31415926}}, {4{32'h27182818}}, 2'd0, 1'b0, 3);
    @(posedge clk);
    #1 req_valid = 2'b10;
    wait_grant(g, w);
    chk("rr_grant", g, 1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    load_pend = 0;
    #1;
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_core_key", core_key, 0);
    chk("arst_core_data", core_data, 0);
    chk("arst_flags", {req_ready, rsp_valid, rsp_timeout, core_load, core_dec, core_size}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 req_valid = 2'b11;
    wait_grant(g, w);
    chk("arst_ptr_grant", g, 0);
    sb.push_back('{0, core_fn(k_a[0], d_a[0], s_a[0], dc_a[0]), 1'b0});
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(0, 6);
    handshake();
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    finish_tb();
  end
endmodule
